// File: rtl/ff_conv_arbiter_pkg.sv
// Shared definitions for the float-to-fixed converter arbiter: state encoding,
// operand width and the default watchdog limit.
package ff_conv_arbiter_pkg;

   localparam int unsigned OP_W            = 32;
   localparam int unsigned TIMEOUT_CYC_DEF = 64;

   typedef enum logic [2:0] {
      StInit,
      StIdle,
      StLoad,
      StWait,
      StClear
   } arb_state_e;

endpackage

// File: rtl/ff_rr_pick.sv
// Combinational round-robin picker: returns the first set request at or after
// the pointer, wrapping modulo N_REQ.
module ff_rr_pick #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned IDW   = 2
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IDW-1:0]   ptr_i,
   output logic [IDW-1:0]   grant_o,
   output logic             valid_o
);

   int idx;

   // Scan from the farthest slot back to the pointer so the nearest set bit wins.
   always_comb begin
      grant_o = '0;
      valid_o = |req_i;
      idx     = 0;
      for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
         idx = int'(ptr_i) + k;
         if (idx >= int'(N_REQ)) begin
            idx = idx - int'(N_REQ);
         end
         if (req_i[idx]) begin
            grant_o = IDW'(idx);
         end
      end
   end

endmodule

// File: rtl/ff_conv_arbiter.sv
// Round-robin arbiter/sequencer sharing one float-to-fixed converter among N_REQ
// requesters. Optional watchdog enabled by defining FF_ARB_TIMEOUT_EN.
module ff_conv_arbiter
   import ff_conv_arbiter_pkg::*;
#(
   parameter int unsigned N_REQ       = 4,
   parameter int unsigned IDW         = 2,
   parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic [N_REQ-1:0]      REQ,
   input  logic [OP_W*N_REQ-1:0] REQ_F,
   output logic [N_REQ-1:0]      DONE,
   output logic [OP_W-1:0]       RESULT,
   output logic [IDW-1:0]        RESULT_ID,
   output logic                  BUSY,
   output logic [OP_W-1:0]       CONV_F,
   output logic                  CONV_BEGIN,
   output logic                  CONV_RST_FSM,
   input  logic                  CONV_ACK,
   input  logic [OP_W-1:0]       CONV_RESULT
`ifdef FF_ARB_TIMEOUT_EN
   ,
   output logic                  TIMEOUT_ERR
`endif
);

   arb_state_e           state_q, state_d;
   logic [IDW-1:0]       ptr_q, ptr_d;
   logic [IDW-1:0]       id_q, id_d;
   logic [OP_W-1:0]      result_q, result_d;
   logic [OP_W-1:0]      conv_f_q, conv_f_d;
   logic [N_REQ-1:0]     done_q, done_d;
   logic                 busy_q, busy_d;
   logic                 begin_q, begin_d;
   logic                 rst_fsm_q, rst_fsm_d;
   logic [IDW-1:0]       grant;
   logic                 any_valid;

`ifdef FF_ARB_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic                 terr_q, terr_d;
   assign TIMEOUT_ERR = terr_q;
`else
   logic                 unused_timeout_cyc;
   assign unused_timeout_cyc = ^TIMEOUT_CYC;
`endif

   ff_rr_pick #(
      .N_REQ (N_REQ),
      .IDW   (IDW)
   ) u_pick (
      .req_i   (REQ),
      .ptr_i   (ptr_q),
      .grant_o (grant),
      .valid_o (any_valid)
   );

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      id_d     = id_q;
      result_d = result_q;
      conv_f_d = conv_f_q;
`ifdef FF_ARB_TIMEOUT_EN
      cnt_d    = cnt_q;
      terr_d   = terr_q;
`endif
      unique case (state_q)
         // INIT lingers until the converter reset pulse has been on the wire a cycle.
         StInit: if (rst_fsm_q) state_d = StIdle;
         StIdle: begin
            if (any_valid) begin
               id_d     = grant;
               conv_f_d = REQ_F[int'(grant)*OP_W +: OP_W];
               state_d  = StLoad;
            end
         end
         StLoad: state_d = StWait;
         StWait: begin
            if (CONV_ACK) begin
               result_d = CONV_RESULT;
               state_d  = StClear;
            end
`ifdef FF_ARB_TIMEOUT_EN
            else if (cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
               result_d = '0;
               terr_d   = 1'b1;
               state_d  = StClear;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         StClear: begin
            ptr_d   = (id_q == IDW'(N_REQ - 1)) ? '0 : id_q + 1'b1;
            state_d = StIdle;
`ifdef FF_ARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         default: state_d = StInit;
      endcase
   end

   // Handshake outputs are registered from the next state so reset drives them all low.
   always_comb begin
      busy_d    = (state_d != StIdle);
      begin_d   = (state_d == StWait);
      rst_fsm_d = (state_d == StInit) || (state_d == StClear);
      done_d    = '0;
      if (state_d == StClear) begin
         done_d[id_q] = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= StInit;
         ptr_q     <= '0;
         id_q      <= '0;
         result_q  <= '0;
         conv_f_q  <= '0;
         done_q    <= '0;
         busy_q    <= 1'b0;
         begin_q   <= 1'b0;
         rst_fsm_q <= 1'b0;
`ifdef FF_ARB_TIMEOUT_EN
         cnt_q     <= '0;
         terr_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         id_q      <= id_d;
         result_q  <= result_d;
         conv_f_q  <= conv_f_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
         begin_q   <= begin_d;
         rst_fsm_q <= rst_fsm_d;
`ifdef FF_ARB_TIMEOUT_EN
         cnt_q     <= cnt_d;
         terr_q    <= terr_d;
`endif
      end
   end

   assign DONE         = done_q;
   assign RESULT       = result_q;
   assign RESULT_ID    = id_q;
   assign BUSY         = busy_q;
   assign CONV_F       = conv_f_q;
   assign CONV_BEGIN   = begin_q;
   assign CONV_RST_FSM = rst_fsm_q;

endmodule

// File: tb/tb_ff_conv_arbiter.sv
// Self-checking bench for ff_conv_arbiter with a behavioural converter and a
// round-robin reference model. Define FF_ARB_TIMEOUT_EN to cover the watchdog.
module tb_ff_conv_arbiter;

   localparam int N = 4;

   logic          CLK = 1'b0;
   logic          RST_N;
   logic [N-1:0]  REQ;
   logic [32*N-1:0] REQ_F;
   logic [N-1:0]  DONE;
   logic [31:0]   RESULT;
   logic [1:0]    RESULT_ID;
   logic          BUSY;
   logic [31:0]   CONV_F;
   logic          CONV_BEGIN;
   logic          CONV_RST_FSM;
   logic          CONV_ACK = 1'b0;
   logic [31:0]   CONV_RESULT = '0;
`ifdef FF_ARB_TIMEOUT_EN
   logic          TIMEOUT_ERR;
`endif

   int checks = 0;
   int errors = 0;

   int          m_ptr = 0;
   int          conv_lat = 4;
   bit          conv_en = 1'b1;
   int          conv_cnt = 0;
   logic [31:0] seen_f = '0;
   logic [31:0] op [N];

   ff_conv_arbiter #(
      .N_REQ       (N),
      .IDW         (2),
      .TIMEOUT_CYC (64)
   ) dut (
      .CLK          (CLK),
      .RST_N        (RST_N),
      .REQ          (REQ),
      .REQ_F        (REQ_F),
      .DONE         (DONE),
      .RESULT       (RESULT),
      .RESULT_ID    (RESULT_ID),
      .BUSY         (BUSY),
      .CONV_F       (CONV_F),
      .CONV_BEGIN   (CONV_BEGIN),
      .CONV_RST_FSM (CONV_RST_FSM),
      .CONV_ACK     (CONV_ACK),
      .CONV_RESULT  (CONV_RESULT)
`ifdef FF_ARB_TIMEOUT_EN
      ,
      .TIMEOUT_ERR  (TIMEOUT_ERR)
`endif
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] conv_fn(input logic [31:0] f);
      return f ^ 32'h4120_0A00;
   endfunction

   // Converter: ACK once BEGIN has been seen conv_lat cycles in a row.
   always @(negedge CLK) begin
      CONV_ACK = 1'b0;
      if (CONV_BEGIN && conv_en) begin
         conv_cnt++;
         if (conv_cnt == conv_lat) begin
            CONV_ACK    = 1'b1;
            CONV_RESULT = conv_fn(CONV_F);
            seen_f      = CONV_F;
         end
      end else begin
         conv_cnt = 0;
      end
   end

   function automatic int model_pick(input logic [N-1:0] pend, input int ptr);
      for (int k = 0; k < N; k++) begin
         if (pend[(ptr + k) % N]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   task automatic wait_done(output logic [N-1:0] d, output bit ok);
      ok = 1'b0;
      d  = '0;
      for (int i = 0; i < 300; i++) begin
         @(negedge CLK);
         if (DONE != '0) begin
            d  = DONE;
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_begin(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge CLK);
         if (CONV_BEGIN) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic count_init_pulses(output int n);
      n = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         if (CONV_RST_FSM) n++;
      end
   endtask

   task automatic test_reset;
      int n;
      RST_N = 1'b0;
      REQ   = '0;
      REQ_F = '0;
      repeat (3) @(negedge CLK);
      checks++;
      if ({BUSY, CONV_BEGIN, CONV_RST_FSM, DONE, RESULT_ID, CONV_F, RESULT} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got busy=%b beg=%b rst=%b done=%b res=%h", BUSY,
                  CONV_BEGIN, CONV_RST_FSM, DONE, RESULT);
      end
`ifdef FF_ARB_TIMEOUT_EN
      checks++;
      if (TIMEOUT_ERR !== 1'b0) begin
         errors++;
         $display("FAIL reset_timeout_err: got %b want 0", TIMEOUT_ERR);
      end
`endif
      RST_N = 1'b1;
      count_init_pulses(n);
      checks++;
      if (n != 1) begin
         errors++;
         $display("FAIL init_pulse: got %0d cycles want 1", n);
      end
      checks++;
      if ({BUSY, CONV_BEGIN, CONV_RST_FSM, DONE, RESULT_ID, CONV_F, RESULT} !== '0) begin
         errors++;
         $display("FAIL idle_after_init: got busy=%b beg=%b rst=%b done=%b", BUSY, CONV_BEGIN,
                  CONV_RST_FSM, DONE);
      end
      m_ptr = 0;
   endtask

   // Raise every requester in mask at once; each drops after its DONE.
   task automatic run_round(input logic [N-1:0] mask, input string name);
      logic [N-1:0] pending;
      logic [N-1:0] d;
      bit           ok;
      int           e;
      pending = mask;
      for (int i = 0; i < N; i++) begin
         op[i] = $urandom;
         REQ_F[i*32 +: 32] = op[i];
      end
      REQ = mask;
      while (pending != '0) begin
         e = model_pick(pending, m_ptr);
         conv_lat = $urandom_range(1, 8);
         wait_done(d, ok);
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL %s_timeout: no DONE, want requester %0d", name, e);
            REQ = '0;
            return;
         end
         checks++;
         if (d !== N'(1 << e)) begin
            errors++;
            $display("FAIL %s_grant: got DONE=%b want %b", name, d, N'(1 << e));
         end
         checks++;
         if (RESULT !== conv_fn(op[e]) || RESULT_ID !== 2'(e)) begin
            errors++;
            $display("FAIL %s_result: got %h id %0d want %h id %0d", name, RESULT, RESULT_ID,
                     conv_fn(op[e]), e);
         end
         checks++;
         if (seen_f !== op[e] || CONV_RST_FSM !== 1'b1) begin
            errors++;
            $display("FAIL %s_operand: got conv_f=%h rst=%b want %h rst=1", name, seen_f,
                     CONV_RST_FSM, op[e]);
         end
         REQ[e]     = 1'b0;
         pending[e] = 1'b0;
         m_ptr      = (e + 1) % N;
         @(negedge CLK);
         checks++;
         if (DONE !== '0) begin
            errors++;
            $display("FAIL %s_done_width: got DONE=%b want 0", name, DONE);
         end
      end
   endtask

   task automatic test_round_robin;
      run_round(4'b1111, "rr_all");
   endtask

   task automatic test_single;
      logic [N-1:0] d;
      bit           ok;
      REQ_F[95:64] = 32'h4120_0000;
      REQ          = 4'b0100;
      conv_lat     = 10;
      wait_begin(ok);
      // Requester drops and its operand changes mid-flight; the op must still complete.
      REQ          = '0;
      REQ_F[95:64] = $urandom;
      wait_done(d, ok);
      checks++;
      if (!ok || d !== 4'b0100) begin
         errors++;
         $display("FAIL single_done: got %b ok=%0d want 0100", d, ok);
      end
      checks++;
      if (RESULT !== 32'h0000_0A00 || RESULT_ID !== 2'd2 || CONV_RST_FSM !== 1'b1) begin
         errors++;
         $display("FAIL single_result: got %h id %0d rst %b want 00000a00 id 2 rst 1", RESULT,
                  RESULT_ID, CONV_RST_FSM);
      end
      @(negedge CLK);
      checks++;
      if (DONE !== '0 || RESULT !== 32'h0000_0A00) begin
         errors++;
         $display("FAIL single_hold: got done=%b res=%h want 0 / 00000a00", DONE, RESULT);
      end
      m_ptr = 3;
   endtask

   task automatic test_wrap;
      run_round(4'b1001, "wrap");
   endtask

   task automatic test_random;
      for (int r = 0; r < 6; r++) begin
         run_round(4'($urandom_range(1, 15)), "rand");
      end
   endtask

   task automatic test_midreset;
      bit ok;
      bit done_seen;
      int n;
      REQ_F[63:32] = $urandom;
      REQ          = 4'b0010;
      conv_lat     = 50;
      wait_begin(ok);
      repeat (3) @(negedge CLK);
      #2 RST_N = 1'b0;
      #1;
      checks++;
      if ({BUSY, CONV_BEGIN, CONV_RST_FSM, DONE, RESULT_ID, CONV_F, RESULT} !== '0) begin
         errors++;
         $display("FAIL midreset_async: got busy=%b beg=%b f=%h res=%h", BUSY, CONV_BEGIN,
                  CONV_F, RESULT);
      end
      REQ       = '0;
      done_seen = 1'b0;
      repeat (2) begin
         @(negedge CLK);
         if (DONE != '0) done_seen = 1'b1;
      end
      RST_N = 1'b1;
      n = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         if (CONV_RST_FSM) n++;
         if (DONE != '0) done_seen = 1'b1;
      end
      checks++;
      if (done_seen || n != 1 || BUSY !== 1'b0) begin
         errors++;
         $display("FAIL midreset_recover: got done_seen=%0d init_pulses=%0d busy=%b want 0/1/0",
                  done_seen, n, BUSY);
      end
      conv_lat = 4;
      m_ptr    = 0;
   endtask

   task automatic test_timeout;
`ifdef FF_ARB_TIMEOUT_EN
      logic [N-1:0] d;
      int           waits;
      run_round(4'b0001, "pre_to");
      REQ_F[31:0] = $urandom;
      REQ         = 4'b0001;
      conv_en     = 1'b0;
      waits       = 0;
      d           = '0;
      for (int i = 0; i < 300; i++) begin
         @(negedge CLK);
         if (CONV_BEGIN) waits++;
         if (DONE != '0) begin
            d = DONE;
            break;
         end
      end
      REQ = '0;
      checks++;
      if (d !== 4'b0001 || waits != 64) begin
         errors++;
         $display("FAIL timeout_done: got done=%b waits=%0d want 0001 / 64", d, waits);
      end
      checks++;
      if (RESULT !== '0 || TIMEOUT_ERR !== 1'b1) begin
         errors++;
         $display("FAIL timeout_result: got res=%h err=%b want 0 / 1", RESULT, TIMEOUT_ERR);
      end
      @(negedge CLK);
      checks++;
      if (BUSY !== 1'b0 || DONE !== '0 || TIMEOUT_ERR !== 1'b1) begin
         errors++;
         $display("FAIL timeout_idle: got busy=%b done=%b err=%b want 0/0/1", BUSY, DONE,
                  TIMEOUT_ERR);
      end
      conv_en = 1'b1;
      m_ptr   = 1;
`endif
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_single();
      test_wrap();
      test_midreset();
      test_random();
      test_timeout();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
